// File: rtl/board_compactor.sv
// -----------------------------------------------------------------------------
// board_compactor
//   Store for the locked cells of a W x H playfield. A 4-cell piece is locked
//   through a valid/ready handshake; afterwards every full row (contiguous or
//   not) is removed by a single bottom-up compaction pass that handles one row
//   per cycle, and the freed rows at the top are filled with EMPTY.
//   A combinational pixel read port and a collision query serve the game FSM
//   and the renderer.
//
//   Optional feature: define BOARD_GARBAGE_EN to enable garbage-row insertion
//   (whole board moves up one row, a colour-7 row with one hole enters at the
//   bottom). Without the macro the garbage ports are ignored and topout is 0.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   lock_valid/ready    piece lock handshake (ready only in IDLE)
//   lock_x/y/color      4 cell coordinates (cell3 in MSBs) and their colour
//   busy                operation in progress
//   done                one-cycle pulse at the end of every operation
//   lines_cleared       rows removed by the last operation, held until next done
//   lock_err            with done: lock rejected (out of bounds or overlap)
//   topout              with done: garbage pushed a non-empty top row off
//   rd_x/rd_y/rd_color  pixel read port, 0 when out of range
//   q_x/q_y/q_ok        collision query, forced 0 while busy
//   garbage_valid/hole  garbage row request and its EMPTY column
// -----------------------------------------------------------------------------
module board_compactor #(
    parameter  int W       = 10,
    parameter  int H       = 20,
    parameter  int COLOR_W = 3,
    localparam int XW      = $clog2(W),
    localparam int YW      = $clog2(H)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               lock_valid,
    output logic               lock_ready,
    input  logic [4*XW-1:0]    lock_x,
    input  logic [4*YW-1:0]    lock_y,
    input  logic [COLOR_W-1:0] lock_color,
    output logic               busy,
    output logic               done,
    output logic [2:0]         lines_cleared,
    output logic               lock_err,
    output logic               topout,
    input  logic [XW-1:0]      rd_x,
    input  logic [YW-1:0]      rd_y,
    output logic [COLOR_W-1:0] rd_color,
    input  logic [4*XW-1:0]    q_x,
    input  logic [4*YW-1:0]    q_y,
    output logic               q_ok,
    input  logic               garbage_valid,
    input  logic [XW-1:0]      garbage_hole
);

    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    typedef logic [W-1:0][COLOR_W-1:0] row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_SCAN,
        S_FILL,
        S_DONE
`ifdef BOARD_GARBAGE_EN
        , S_GARB
`endif
    } state_t;

    state_t               state_q, state_d;
    row_t                 board [H];
    logic [4*XW-1:0]      lx_q;
    logic [4*YW-1:0]      ly_q;
    logic [COLOR_W-1:0]   lc_q;
    logic [YW-1:0]        r_q;       // row being read during SCAN
    logic [YW-1:0]        wp_q;      // row being written during SCAN/FILL
    logic [2:0]           cnt_q;     // full rows found so far
    logic [2:0]           fill_q;    // EMPTY rows still to write
    logic [2:0]           lines_q;
    logic                 err_q;
    logic                 lock_ok;
    logic                 q_free;
    logic                 row_full;
    logic [2:0]           cnt_next;
`ifdef BOARD_GARBAGE_EN
    logic                 top_q;
    logic [XW-1:0]        hole_q;
`else
    logic                 unused_garbage;
    assign unused_garbage = garbage_valid ^ (^garbage_hole);
`endif

    // True when all four cells lie on the board and are EMPTY.
    function automatic logic cells_free(input row_t b [H],
                                        input logic [4*XW-1:0] xs,
                                        input logic [4*YW-1:0] ys);
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = xs[i*XW +: XW];
            y = ys[i*YW +: YW];
            if (x > X_MAX || y > Y_MAX) ok = 1'b0;
            else if (b[y][x] != '0)      ok = 1'b0;
        end
        return ok;
    endfunction

    assign lock_ok  = cells_free(board, lx_q, ly_q);
    assign q_free   = cells_free(board, q_x, q_y);
    assign cnt_next = cnt_q + {2'b00, row_full};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        row_full = 1'b1;
        for (int x = 0; x < W; x++)
            if (board[r_q][x] == '0) row_full = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lock_valid) state_d = S_LOCK;
`ifdef BOARD_GARBAGE_EN
                else if (garbage_valid) state_d = S_GARB;
`endif
            end
            S_LOCK: state_d = lock_ok ? S_SCAN : S_DONE;
            S_SCAN: if (r_q == '0) state_d = (cnt_next != '0) ? S_FILL : S_DONE;
            S_FILL: if (fill_q == 3'd1) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
`ifdef BOARD_GARBAGE_EN
            S_GARB: state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: the board is a register array, not a RAM, so it can and
            // must be cleared by reset: reset mid-operation returns it EMPTY.
            for (int y = 0; y < H; y++) board[y] <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            lc_q    <= '0;
            r_q     <= '0;
            wp_q    <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            lines_q <= '0;
            err_q   <= 1'b0;
`ifdef BOARD_GARBAGE_EN
            top_q   <= 1'b0;
            hole_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lock_valid) begin
                        lx_q <= lock_x;
                        ly_q <= lock_y;
                        lc_q <= lock_color;
                    end
`ifdef BOARD_GARBAGE_EN
                    else if (garbage_valid) hole_q <= garbage_hole;
`endif
                end
                S_LOCK: begin
                    err_q <= ~lock_ok;
`ifdef BOARD_GARBAGE_EN
                    top_q <= 1'b0;
`endif
                    r_q   <= Y_MAX;
                    wp_q  <= Y_MAX;
                    cnt_q <= '0;
                    if (lock_ok) begin
                        // Duplicate coordinates simply rewrite the same cell.
                        for (int i = 0; i < 4; i++)
                            board[ly_q[i*YW +: YW]][lx_q[i*XW +: XW]] <= lc_q;
                    end else begin
                        lines_q <= '0;
                    end
                end
                S_SCAN: begin
                    // Rows above r are still untouched, so row r is always read
                    // in its original form; wp never passes above r.
                    if (row_full) begin
                        cnt_q <= cnt_next;
                    end else begin
                        if (wp_q != r_q) board[wp_q] <= board[r_q];
                        wp_q <= wp_q - YW'(1);
                    end
                    r_q <= r_q - YW'(1);
                    if (r_q == '0) begin
                        fill_q <= cnt_next;
                        if (cnt_next == '0) lines_q <= '0;
                    end
                end
                S_FILL: begin
                    board[wp_q] <= '0;
                    wp_q   <= wp_q - YW'(1);
                    fill_q <= fill_q - 3'd1;
                    if (fill_q == 3'd1) lines_q <= cnt_q;
                end
`ifdef BOARD_GARBAGE_EN
                S_GARB: begin
                    top_q   <= |board[0];
                    err_q   <= 1'b0;
                    lines_q <= '0;
                    for (int y = 0; y < H - 1; y++) board[y] <= board[y+1];
                    // A hole at or beyond W leaves a full row; it stays.
                    for (int x = 0; x < W; x++)
                        board[H-1][x] <= (hole_q == XW'(x)) ? '0 : COLOR_W'(7);
                end
`endif
                default: ;
            endcase
        end
    end

    assign lock_ready    = (state_q == S_IDLE);
    assign busy          = ~lock_ready;
    assign done          = (state_q == S_DONE);
    assign lines_cleared = lines_q;
    assign lock_err      = done & err_q;
`ifdef BOARD_GARBAGE_EN
    assign topout        = done & top_q;
`else
    assign topout        = 1'b0;
`endif
    assign q_ok          = q_free & ~busy;
    assign rd_color      = (rd_x <= X_MAX && rd_y <= Y_MAX) ? board[rd_y][rd_x] : '0;

endmodule

// File: tb/tb_board_compactor.sv
// -----------------------------------------------------------------------------
// tb_board_compactor
//   Self-checking bench for board_compactor: a table of directed lock vectors,
//   hand-written multi-cycle sequences (held lock_valid, reset mid-scan,
//   garbage rows) and random locks against a row-list reference model.
// -----------------------------------------------------------------------------
module tb_board_compactor;
    localparam int W  = 10;
    localparam int H  = 20;
    localparam int CW = 3;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lock_valid, lock_ready;
    logic [4*XW-1:0] lock_x, q_x;
    logic [4*YW-1:0] lock_y, q_y;
    logic [CW-1:0] lock_color, rd_color;
    logic          busy, done, lock_err, topout, q_ok, garbage_valid;
    logic [2:0]    lines_cleared;
    logic [XW-1:0] rd_x, garbage_hole;
    logic [YW-1:0] rd_y;

    board_compactor #(.W(W), .H(H), .COLOR_W(CW)) dut (
        .Clk(clk), .Reset_n(rst_n),
        .lock_valid(lock_valid), .lock_ready(lock_ready),
        .lock_x(lock_x), .lock_y(lock_y), .lock_color(lock_color),
        .busy(busy), .done(done), .lines_cleared(lines_cleared),
        .lock_err(lock_err), .topout(topout),
        .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
        .q_x(q_x), .q_y(q_y), .q_ok(q_ok),
        .garbage_valid(garbage_valid), .garbage_hole(garbage_hole)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int accepts  = 0;
    int mdl [H][W];

    always @(posedge clk) if (lock_valid && lock_ready) accepts++;

    typedef struct {
        bit rst;
        int x[4];
        int y[4];
        int c;
        int err;
        int lines;
        int px, py, pc;   // probe cell checked after the op (px < 0: none)
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_clear_board();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) mdl[y][x] = 0;
    endtask

    task automatic m_lock(input int xs[4], input int ys[4], input int c,
                          output int err, output int lines);
        int keep[$];
        int nb [H][W];
        bit full;
        err = 0; lines = 0;
        for (int i = 0; i < 4; i++) begin
            if (xs[i] >= W || ys[i] >= H) err = 1;
            else if (mdl[ys[i]][xs[i]] != 0) err = 1;
        end
        if (err) return;
        for (int i = 0; i < 4; i++) mdl[ys[i]][xs[i]] = c;
        // keep the non-full rows bottom-up, stack them at the bottom
        for (int r = H - 1; r >= 0; r--) begin
            full = 1;
            for (int x = 0; x < W; x++) if (mdl[r][x] == 0) full = 0;
            if (full) lines++;
            else keep.push_back(r);
        end
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) nb[y][x] = 0;
        for (int k = 0; k < keep.size(); k++)
            for (int x = 0; x < W; x++) nb[H-1-k][x] = mdl[keep[k]][x];
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) mdl[y][x] = nb[y][x];
    endtask

    task automatic m_garbage(input int hole, output int top);
        top = 0;
        for (int x = 0; x < W; x++) if (mdl[0][x] != 0) top = 1;
        for (int y = 0; y < H - 1; y++) for (int x = 0; x < W; x++) mdl[y][x] = mdl[y+1][x];
        for (int x = 0; x < W; x++) mdl[H-1][x] = (x == hole) ? 0 : 7;
    endtask

    function automatic int m_free(input int xs[4], input int ys[4]);
        for (int i = 0; i < 4; i++) begin
            if (xs[i] >= W || ys[i] >= H) return 0;
            if (mdl[ys[i]][xs[i]] != 0) return 0;
        end
        return 1;
    endfunction

    // ---------------- drivers / monitors ----------------
    task automatic do_reset();
        rst_n = 1'b0; lock_valid = 1'b0; garbage_valid = 1'b0;
        lock_x = '0; lock_y = '0; lock_color = '0; garbage_hole = '0;
        q_x = '0; q_y = '0; rd_x = '0; rd_y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        m_clear_board();
    endtask

    task automatic drive_piece(input int xs[4], input int ys[4], input int c);
        for (int i = 0; i < 4; i++) begin
            lock_x[i*XW +: XW] = XW'(xs[i]);
            lock_y[i*YW +: YW] = YW'(ys[i]);
        end
        lock_color = CW'(c);
    endtask

    // Called right after the accept edge (cycle 1); returns the cycle of done.
    task automatic wait_done(output int cyc, output int err, output int lines, output int top);
        cyc = 1; err = -1; lines = -1; top = -1;
        for (int k = 0; k < 4 * H; k++) begin
            @(negedge clk);
            if (done) begin
                err = int'(lock_err); lines = int'(lines_cleared); top = int'(topout);
                return;
            end
            @(posedge clk);
            cyc++;
        end
        check("done_timeout", 0, 1);
        cyc = -1;
    endtask

    task automatic run_lock(input int xs[4], input int ys[4], input int c,
                            output int cyc, output int err, output int lines);
        int top;
        @(negedge clk);
        drive_piece(xs, ys, c);
        lock_valid = 1'b1;
        @(posedge clk);
        #1 lock_valid = 1'b0;
        wait_done(cyc, err, lines, top);
    endtask

    task automatic rd(input int x, input int y, output int c);
        rd_x = XW'(x); rd_y = YW'(y);
        #1 c = int'(rd_color);
    endtask

    task automatic compare_board(input string name);
        int bad, bx, by, c;
        bad = 0; bx = -1; by = -1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                rd(x, y, c);
                if (c != mdl[y][x]) begin
                    if (bad == 0) begin bx = x; by = y; end
                    bad++;
                end
            end
        check($sformatf("%s_board_bad_cells(first x=%0d y=%0d)", name, bx, by), bad, 0);
    endtask

    task automatic add(input bit rst, input int x0, x1, x2, x3, input int y0, y1, y2, y3,
                       input int c, input int err, input int lines,
                       input int px, input int py, input int pc);
        vec_t v;
        v.rst = rst; v.c = c; v.err = err; v.lines = lines;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.y[0] = y0; v.y[1] = y1; v.y[2] = y2; v.y[3] = y3;
        v.px = px; v.py = py; v.pc = pc;
        vecs.push_back(v);
    endtask

    // Row y filled at x = 0..8 (x = 9 stays EMPTY), three locks.
    task automatic add_row9(input bit rst, input int y, input int c);
        add(rst, 0, 1, 2, 3, y, y, y, y, c, 0, 0, -1, 0, 0);
        add(0,   4, 5, 6, 7, y, y, y, y, c, 0, 0, -1, 0, 0);
        add(0,   8, 8, 8, 8, y, y, y, y, c, 0, 0, -1, 0, 0);
    endtask

    initial begin
        int cyc, err, lines, top, merr, mlines, c, a0, seen_q, saw_ready;
        int xs[4], ys[4];
        vec_t v;

        do_reset();
        check("rst_lock_ready", int'(lock_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_lock_err", int'(lock_err), 0);
        check("rst_topout", int'(topout), 0);
        check("rst_lines", int'(lines_cleared), 0);
        compare_board("rst");

        // ---------------- directed table ----------------
        // O-piece, no clear
        add(1, 0, 1, 0, 1, 18, 18, 19, 19, 2, 0, 0, 1, 19, 2);
        // rows 19/17 full except x=9, row 18 half full, I at x=9 -> 2 lines
        add_row9(1, 19, 1);
        add_row9(0, 17, 3);
        add(0, 0, 1, 2, 3, 18, 18, 18, 18, 4, 0, 0, -1, 0, 0);
        add(0, 4, 4, 4, 4, 18, 18, 18, 18, 4, 0, 0, -1, 0, 0);
        add(0, 9, 9, 9, 9, 16, 17, 18, 19, 5, 0, 2, 0, 19, 4);
        // rows 16..19 full except x=9, I at x=9 -> 4 lines, board empty
        add_row9(1, 16, 1);
        add_row9(0, 17, 2);
        add_row9(0, 18, 3);
        add_row9(0, 19, 4);
        add(0, 9, 9, 9, 9, 16, 17, 18, 19, 6, 0, 4, 9, 19, 0);
        // single cell, then overlap and x = W rejections
        add(0, 0, 0, 0, 0, 19, 19, 19, 19, 2, 0, 0, 0, 19, 2);
        add(0, 0, 1, 2, 3, 19, 19, 19, 19, 3, 1, 0, 1, 19, 0);
        add(0, W, 0, 1, 2, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.rst) do_reset();
            check($sformatf("v%0d_ready", i), int'(lock_ready), 1);
            run_lock(v.x, v.y, v.c, cyc, err, lines);
            m_lock(v.x, v.y, v.c, merr, mlines);
            check($sformatf("v%0d_lock_err", i), err, v.err);
            check($sformatf("v%0d_lines", i), lines, v.lines);
            check($sformatf("v%0d_done_cycle", i), cyc, v.err ? 2 : H + v.lines + 2);
            compare_board($sformatf("v%0d", i));
            check($sformatf("v%0d_lines_hold", i), int'(lines_cleared), v.lines);
            if (v.px >= 0) begin
                rd(v.px, v.py, c);
                check($sformatf("v%0d_probe", i), c, v.pc);
            end
        end

        // out-of-range read returns 0 (cell (0,19) holds colour 2 here)
        rd(W, 19, c);  check("rd_x_oor", c, 0);
        rd(0, H, c);   check("rd_y_oor", c, 0);
        rd(15, 31, c); check("rd_xy_oor", c, 0);

        // ---------------- lock_valid held during busy, q_ok gating ----------------
        do_reset();
        a0 = accepts; seen_q = 0; saw_ready = 0;
        xs = '{0, 1, 0, 1}; ys = '{18, 18, 19, 19};
        @(negedge clk);
        drive_piece(xs, ys, 2);
        for (int i = 0; i < 4; i++) begin
            q_x[i*XW +: XW] = XW'(5 + i);
            q_y[i*YW +: YW] = YW'(10);
        end
        lock_valid = 1'b1;
        @(posedge clk);
        cyc = 1;
        for (int k = 0; k < 4 * H; k++) begin
            @(negedge clk);
            if (busy) begin
                if (q_ok) seen_q = 1;
                if (lock_ready) saw_ready = 1;
            end
            if (done) begin lock_valid = 1'b0; break; end
            @(posedge clk);
            cyc++;
        end
        lock_valid = 1'b0;
        m_lock(xs, ys, 2, merr, mlines);
        check("held_done_cycle", cyc, H + 2);
        check("held_qok_busy", seen_q, 0);
        check("held_ready_busy", saw_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("held_one_accept", accepts - a0, 1);
        check("held_idle_busy", int'(busy), 0);
        check("held_qok_idle", int'(q_ok), 1);
        compare_board("held");

        // ---------------- reset during SCAN ----------------
        xs = '{5, 5, 5, 5}; ys = '{19, 19, 19, 19};
        @(negedge clk);
        drive_piece(xs, ys, 3);
        lock_valid = 1'b1;
        @(posedge clk);
        #1 lock_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scan_busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(lock_ready), 1);
        check("midrst_done", int'(done), 0);
        m_clear_board();
        compare_board("midrst");
        @(negedge clk) rst_n = 1'b1;

`ifdef BOARD_GARBAGE_EN
        // ---------------- garbage rows ----------------
        do_reset();
        xs = '{4, 4, 4, 4}; ys = '{0, 0, 0, 0};
        run_lock(xs, ys, 6, cyc, err, lines);
        m_lock(xs, ys, 6, merr, mlines);
        xs = '{2, 2, 2, 2}; ys = '{19, 19, 19, 19};
        run_lock(xs, ys, 1, cyc, err, lines);
        m_lock(xs, ys, 1, merr, mlines);
        @(negedge clk);
        garbage_hole = XW'(3); garbage_valid = 1'b1;
        @(posedge clk);
        #1 garbage_valid = 1'b0;
        wait_done(cyc, err, lines, top);
        m_garbage(3, merr);
        check("garb_done_cycle", cyc, 2);
        check("garb_topout", top, 1);
        check("garb_lines", lines, 0);
        check("garb_err", err, 0);
        compare_board("garb");
        rd(3, 19, c); check("garb_hole", c, 0);
        rd(0, 19, c); check("garb_fill", c, 7);
        rd(2, 18, c); check("garb_shift", c, 1);
        // hole beyond W: full row that stays, no topout
        @(negedge clk);
        garbage_hole = XW'(15); garbage_valid = 1'b1;
        @(posedge clk);
        #1 garbage_valid = 1'b0;
        wait_done(cyc, err, lines, top);
        m_garbage(15, merr);
        check("garb_full_topout", top, merr);
        check("garb_full_lines", lines, 0);
        compare_board("garb_full");
        // lock and garbage together: lock first, garbage afterwards
        xs = '{6, 6, 6, 6}; ys = '{17, 17, 17, 17};
        @(negedge clk);
        drive_piece(xs, ys, 5);
        lock_valid = 1'b1; garbage_valid = 1'b1; garbage_hole = XW'(0);
        @(posedge clk);
        #1 lock_valid = 1'b0;
        wait_done(cyc, err, lines, top);
        m_lock(xs, ys, 5, merr, mlines);
        check("both_lock_first_cycle", cyc, H + mlines + 2);
        @(posedge clk);
        #1 garbage_valid = 1'b0;
        wait_done(cyc, err, lines, top);
        m_garbage(0, merr);
        check("both_garb_cycle", cyc, 2);
        check("both_garb_topout", top, merr);
        compare_board("both");
`else
        // garbage request is ignored
        @(negedge clk);
        garbage_hole = XW'(3); garbage_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("garb_off_busy", int'(busy), 0);
        check("garb_off_topout", int'(topout), 0);
        garbage_valid = 1'b0;
        compare_board("garb_off");
`endif

        // ---------------- random locks vs model ----------------
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int shape, x0, y0, col;
            shape = int'($urandom_range(0, 3));
            col   = int'($urandom_range(1, 7));
            case (shape)
                0: begin
                    x0 = int'($urandom_range(0, W - 1)); y0 = int'($urandom_range(H - 5, H - 1));
                    for (int i = 0; i < 4; i++) begin xs[i] = x0 + i; ys[i] = y0; end
                end
                1: begin
                    x0 = int'($urandom_range(0, W)); y0 = int'($urandom_range(H - 8, H - 4));
                    for (int i = 0; i < 4; i++) begin xs[i] = x0; ys[i] = y0 + i; end
                end
                default: begin
                    x0 = int'($urandom_range(0, W - 1)); y0 = int'($urandom_range(H - 3, H - 1));
                    for (int i = 0; i < 4; i++) begin xs[i] = x0; ys[i] = y0; end
                end
            endcase
            run_lock(xs, ys, col, cyc, err, lines);
            m_lock(xs, ys, col, merr, mlines);
            check($sformatf("r%0d_lock_err", n), err, merr);
            check($sformatf("r%0d_lines", n), lines, mlines);
            check($sformatf("r%0d_done_cycle", n), cyc, merr ? 2 : H + mlines + 2);
            compare_board($sformatf("r%0d", n));
            for (int i = 0; i < 4; i++) begin
                xs[i] = int'($urandom_range(0, W));
                ys[i] = int'($urandom_range(H - 6, H - 1));
                q_x[i*XW +: XW] = XW'(xs[i]);
                q_y[i*YW +: YW] = YW'(ys[i]);
            end
            #1 check($sformatf("r%0d_q_ok", n), int'(q_ok), m_free(xs, ys));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
